ss_mux_driver: RTL and testbench

SS_MUX_DRIVER -- requirements
Module: ss_mux_driver

---
 rtl/ss_mux_driver.sv | 183 ++++++++++++++++++
 tb/tb_ss_mux_driver.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/ss_mux_driver.sv
// rtl/ss_mux_driver.sv - multiplexed seven-segment driver with frame-committed data, LZ blanking, blink and PWM dimming
module ss_mux_driver #(
  parameter int NUM_DIGITS = 8,
  parameter int DIV_BITS   = 17,
  parameter int PWM_BITS   = 8,
  parameter int BLINK_BITS = 25
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic [NUM_DIGITS-1:0]   blink_in,
  input  logic                    lz_blank_en,
  input  logic                    load,
  input  logic [PWM_BITS-1:0]     brightness,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic [7:0]              seg_n,
  output logic                    frame_start
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  // Active-high gfedcba pattern for a hex code
  function automatic logic [6:0] hex_glyph(input logic [3:0] code);
    case (code)
      4'h0: hex_glyph = 7'h3F;
      4'h1: hex_glyph = 7'h06;
      4'h2: hex_glyph = 7'h5B;
      4'h3: hex_glyph = 7'h4F;
      4'h4: hex_glyph = 7'h66;
      4'h5: hex_glyph = 7'h6D;
      4'h6: hex_glyph = 7'h7D;
      4'h7: hex_glyph = 7'h07;
      4'h8: hex_glyph = 7'h7F;
      4'h9: hex_glyph = 7'h6F;
      4'hA: hex_glyph = 7'h77;
      4'hB: hex_glyph = 7'h7C;
      4'hC: hex_glyph = 7'h39;
      4'hD: hex_glyph = 7'h5E;
      4'hE: hex_glyph = 7'h79;
      default: hex_glyph = 7'h71;
    endcase
  endfunction

  logic [DIV_BITS-1:0]     presc_q, presc_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [PWM_BITS-1:0]     pwm_q, pwm_d;
  logic [BLINK_BITS-1:0]   blink_q, blink_d;

  logic [4*NUM_DIGITS-1:0] pend_digits_q, pend_digits_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic [NUM_DIGITS-1:0]   pend_blank_q, pend_blank_d;
  logic [NUM_DIGITS-1:0]   pend_blink_q, pend_blink_d;
  logic                    pend_lz_q, pend_lz_d;

  logic [4*NUM_DIGITS-1:0] act_digits_q, act_digits_d;
  logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;
  logic [NUM_DIGITS-1:0]   act_blank_q, act_blank_d;
  logic [NUM_DIGITS-1:0]   act_blink_q, act_blink_d;
  logic                    act_lz_q, act_lz_d;

  logic [NUM_DIGITS-1:0]   an_n_q, an_n_d;
  logic [7:0]              seg_n_q, seg_n_d;
  logic                    frame_start_q, frame_start_d;

  logic                    tick;
  logic                    commit;
  logic [NUM_DIGITS-1:0]   lz_mask;
  logic                    lz_run;
  logic [3:0]              cur_code;
  logic                    pwm_on;
  logic                    blanked;

  // Free-running counters, digit scan index and frame-wrap commit strobe
  always_comb begin
    presc_d = presc_q + DIV_BITS'(1);
    pwm_d   = pwm_q + PWM_BITS'(1);
    blink_d = blink_q + BLINK_BITS'(1);
    tick    = &presc_q;
    commit  = tick && (idx_q == LAST_IDX);
    idx_d   = idx_q;
    if (tick) begin
      idx_d = commit ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Pending set captures on load; active set takes the pre-load pending contents at commit
  always_comb begin
    pend_digits_d = pend_digits_q;
    pend_dp_d     = pend_dp_q;
    pend_blank_d  = pend_blank_q;
    pend_blink_d  = pend_blink_q;
    pend_lz_d     = pend_lz_q;
    if (load) begin
      pend_digits_d = digits_in;
      pend_dp_d     = dp_in;
      pend_blank_d  = blank_in;
      pend_blink_d  = blink_in;
      pend_lz_d     = lz_blank_en;
    end
    act_digits_d = act_digits_q;
    act_dp_d     = act_dp_q;
    act_blank_d  = act_blank_q;
    act_blink_d  = act_blink_q;
    act_lz_d     = act_lz_q;
    if (commit) begin
      act_digits_d = pend_digits_q;
      act_dp_d     = pend_dp_q;
      act_blank_d  = pend_blank_q;
      act_blink_d  = pend_blink_q;
      act_lz_d     = pend_lz_q;
    end
  end

  // Leading-zero mask: blank from the top digit down while code is zero with no dp; digit 0 always shown
  always_comb begin
    lz_mask = '0;
    lz_run  = act_lz_q;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      lz_run     = lz_run && (act_digits_q[4*k +: 4] == 4'h0) && !act_dp_q[k];
      lz_mask[k] = lz_run;
    end
  end

  // Next output values for the digit currently selected by the scan index
  always_comb begin
    cur_code      = act_digits_q[{idx_q, 2'b00} +: 4];
    pwm_on        = (pwm_q < brightness);
    blanked       = act_blank_q[idx_q] | lz_mask[idx_q] |
                    (act_blink_q[idx_q] & blink_q[BLINK_BITS-1]);
    an_n_d        = pwm_on ? ~(NUM_DIGITS'(1) << idx_q) : '1;
    seg_n_d       = (pwm_on && !blanked) ? {~act_dp_q[idx_q], ~hex_glyph(cur_code)} : 8'hFF;
    frame_start_d = commit;
  end

  // State and registered outputs; reset blanks everything and drops pending data
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q       <= '0;
      idx_q         <= '0;
      pwm_q         <= '0;
      blink_q       <= '0;
      pend_digits_q <= '0;
      pend_dp_q     <= '0;
      pend_blank_q  <= '1;
      pend_blink_q  <= '0;
      pend_lz_q     <= 1'b0;
      act_digits_q  <= '0;
      act_dp_q      <= '0;
      act_blank_q   <= '1;
      act_blink_q   <= '0;
      act_lz_q      <= 1'b0;
      an_n_q        <= '1;
      seg_n_q       <= 8'hFF;
      frame_start_q <= 1'b0;
    end else begin
      presc_q       <= presc_d;
      idx_q         <= idx_d;
      pwm_q         <= pwm_d;
      blink_q       <= blink_d;
      pend_digits_q <= pend_digits_d;
      pend_dp_q     <= pend_dp_d;
      pend_blank_q  <= pend_blank_d;
      pend_blink_q  <= pend_blink_d;
      pend_lz_q     <= pend_lz_d;
      act_digits_q  <= act_digits_d;
      act_dp_q      <= act_dp_d;
      act_blank_q   <= act_blank_d;
      act_blink_q   <= act_blink_d;
      act_lz_q      <= act_lz_d;
      an_n_q        <= an_n_d;
      seg_n_q       <= seg_n_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign an_n        = an_n_q;
  assign seg_n       = seg_n_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_ss_mux_driver.sv
// tb/tb_ss_mux_driver.sv - scoreboard bench for ss_mux_driver
module tb_ss_mux_driver;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] digits_in;
  logic [3:0]  dp_in, blank_in, blink_in;
  logic        lz_blank_en, load;
  logic [3:0]  brightness;
  logic [3:0]  an_n;
  logic [7:0]  seg_n;
  logic        frame_start;

  ss_mux_driver #(
    .NUM_DIGITS(4), .DIV_BITS(2), .PWM_BITS(4), .BLINK_BITS(6)
  ) dut (
    .clk(clk), .reset(reset), .digits_in(digits_in), .dp_in(dp_in),
    .blank_in(blank_in), .blink_in(blink_in), .lz_blank_en(lz_blank_en),
    .load(load), .brightness(brightness), .an_n(an_n), .seg_n(seg_n),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         abs_t;
    logic [3:0] an;
    logic [7:0] seg;
    logic       fs;
    string      tag;
  } exp_t;

  exp_t       q[$];
  int         t = 0;
  int         base = 0;
  int         n_pass = 0;
  int         n_total = 0;
  logic [7:0] gl [4];
  logic [3:0] bmask;

  task automatic push(input int abs_t, input logic [3:0] an, input logic [7:0] seg,
                      input logic fs, input string tag);
    exp_t e;
    e.abs_t = abs_t; e.an = an; e.seg = seg; e.fs = fs; e.tag = tag;
    q.push_back(e);
  endtask

  // k counts non-reset clock edges since reset release; digit/pwm/blink state before edge k is k-1
  task automatic push_range(input int k0, input int k1, input int br, input string tag);
    int s, ix, pw;
    logic on, bl;
    logic [3:0] an;
    logic [7:0] sg;
    for (int k = k0; k <= k1; k++) begin
      s  = k - 1;
      ix = (s >> 2) & 3;
      pw = s & 15;
      bl = ((s >> 5) & 1) == 1;
      on = pw < br;
      an = on ? ~(4'b0001 << ix) : 4'hF;
      sg = (on && !(bmask[ix] && bl)) ? gl[ix] : 8'hFF;
      push(base + k, an, sg, (k % 16) == 0, tag);
    end
  endtask

  task automatic push_frame(input int m, input int br, input string tag);
    push_range(16*m + 1, 16*m + 16, br, tag);
  endtask

  task automatic set_gl(input logic [7:0] g0, input logic [7:0] g1,
                        input logic [7:0] g2, input logic [7:0] g3);
    gl[0] = g0; gl[1] = g1; gl[2] = g2; gl[3] = g3;
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bk,
                         input logic [3:0] bl, input logic lz);
    digits_in = d; dp_in = dp; blank_in = bk; blink_in = bl; lz_blank_en = lz; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_rel(input int k);
    int guard;
    guard = 0;
    while ((t - base) != k) begin
      @(negedge clk);
      guard++;
      if (guard > 2000) begin
        $display("FAIL wait_rel timeout: rel=%0d required=%0d", t - base, k);
        $fatal(1);
      end
    end
  endtask

  // Monitor: every cycle the DUT presents an output; pop due expectations and compare
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      t++;
      if (reset) base = t;
      @(negedge clk);
      while (q.size() > 0 && q[0].abs_t <= t) begin
        e = q.pop_front();
        n_total++;
        if (e.abs_t < t) begin
          $display("FAIL %s missed: at t=%0d required t=%0d", e.tag, t, e.abs_t);
        end else if (an_n !== e.an || seg_n !== e.seg || frame_start !== e.fs) begin
          $display("FAIL %s t=%0d: an_n=%b seg_n=%h frame_start=%b required an_n=%b seg_n=%h frame_start=%b",
                   e.tag, t, an_n, seg_n, frame_start, e.an, e.seg, e.fs);
        end else begin
          n_pass++;
        end
      end
    end
  end

  // Stimulus: directed scenarios, expectations pushed one frame ahead
  initial begin
    int guard;
    reset = 1'b1; load = 1'b0; digits_in = '0; dp_in = '0; blank_in = '0;
    blink_in = '0; lz_blank_en = 1'b0; brightness = 4'd15; bmask = 4'b0000;
    push(1, 4'hF, 8'hFF, 1'b0, "reset_state");
    repeat (3) @(negedge clk);
    reset = 1'b0;

    set_gl(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    push_frame(0, 15, "idle_blank");
    wait_rel(2);  do_load(16'hF018, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    wait_rel(16); set_gl(8'h80, 8'hF9, 8'hC0, 8'h8E); push_frame(1, 15, "hex_8_1_0_F");
    wait_rel(18); do_load(16'h0005, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    wait_rel(32); set_gl(8'h92, 8'hFF, 8'hFF, 8'hFF); push_frame(2, 15, "lz_blank");
    wait_rel(34); do_load(16'h0005, 4'b0100, 4'b0000, 4'b0000, 1'b1);
    wait_rel(48); set_gl(8'h92, 8'hC0, 8'h40, 8'hFF); push_frame(3, 15, "lz_dp_stop");
    wait_rel(63); do_load(16'hA5C3, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    push_frame(4, 15, "load_on_commit_old");
    wait_rel(80); set_gl(8'hB0, 8'hC6, 8'h92, 8'h88); push_frame(5, 15, "load_on_commit_new");
    wait_rel(96);  brightness = 4'd4; push_frame(6, 4, "pwm_4");
    wait_rel(112); brightness = 4'd0; push_frame(7, 0, "pwm_0");
    wait_rel(114); do_load(16'hA5C3, 4'b0000, 4'b0000, 4'b0010, 1'b0);
    wait_rel(128); brightness = 4'd15; bmask = 4'b0010;
    for (int m = 8; m < 12; m++) push_frame(m, 15, "blink_d1");
    wait_rel(192); push_range(193, 200, 15, "pre_reset");
    wait_rel(194); do_load(16'hF018, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    wait_rel(200); reset = 1'b1; push(base + 201, 4'hF, 8'hFF, 1'b0, "reset_mid_frame");
    @(negedge clk);
    reset = 1'b0;
    set_gl(8'hFF, 8'hFF, 8'hFF, 8'hFF); bmask = 4'b0000;
    push_frame(0, 15, "post_reset_f0");
    push_frame(1, 15, "post_reset_pending_dropped");
    wait_rel(32);

    guard = 0;
    while (q.size() != 0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    n_total++;
    if (q.size() != 0) $display("FAIL scoreboard_drain: %0d left, required 0", q.size());
    else n_pass++;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
